wb_stage_skid: RTL



---
 rtl/wb_stage_skid_pkg.sv | 15 +
 rtl/wb_stage_skid_if.sv | 31 +++
 rtl/wb_stage_skid_entry_reg.sv | 45 ++++
 rtl/wb_stage_skid.sv | 106 ++++++++++
 4 files changed

// File: rtl/wb_stage_skid_pkg.sv
// Shared types and constants for the write-back stage skid register.
package wb_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  typedef struct packed {
    logic [REGADDR_W-1:0] dst;
    logic                 wen;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  localparam logic [REGADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_stage_skid_if.sv
// MEM->WB handshake bundle: input side from the MEM stage, output side to the register file.
interface wb_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [ADDR_W-1:0] in_dst_i;
  logic              in_wen_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [ADDR_W-1:0] out_dst_o;
  logic              out_wen_o;
  logic [DATA_W-1:0] out_data_o;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid may not depend on ready, and an offered entry stays stable until it transfers.
  modport slave (
    input  flush_i, in_valid_i, in_dst_i, in_wen_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_dst_o, out_wen_o, out_data_o
  );

  modport master (
    output flush_i, in_valid_i, in_dst_i, in_wen_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_dst_o, out_wen_o, out_data_o
  );

endinterface

// File: rtl/wb_stage_skid_entry_reg.sv
// One valid flag plus payload; clear wins over load, payload only moves on load.
module wb_entry_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_dst,
  output logic              o_wen,
  output logic [DATA_W-1:0] o_data
);

  logic              r_vld;
  logic [ADDR_W-1:0] r_dst;
  logic              r_wen;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_dst  <= '0;
      r_wen  <= 1'b0;
      r_data <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_dst  <= i_dst;
      r_wen  <= i_wen;
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_dst  = r_dst;
  assign o_wen  = r_wen;
  assign o_data = r_data;

endmodule

// File: rtl/wb_stage_skid.sv
// Write-back stage register with a 2-entry skid so in_ready_o is a pure flop output.
// Optional stall counter output stall_cnt_o is built when WB_STAGE_STALL_CNT_EN is defined.
import wb_pkg::*;

module wb_stage_skid #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 5,
  parameter int ZERO_REG_PROTECT = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_skid_if.slave   bus
`ifdef WB_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  if (CNT_W < 1 || DATA_W < 1 || ADDR_W < 1) begin : g_param_check
    $error("wb_stage_skid: widths must be at least 1");
  end

  logic              w_in_fire;
  logic              w_cap_wen;
  logic              w_main_take;
  logic              w_main_load;
  logic              w_main_clr;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic              w_main_vld;
  logic [ADDR_W-1:0] w_main_dst;
  logic              w_main_wen;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_vld;
  logic [ADDR_W-1:0] w_skid_dst;
  logic              w_skid_wen;
  logic [DATA_W-1:0] w_skid_data;
  logic [ADDR_W-1:0] w_main_in_dst;
  logic              w_main_in_wen;
  logic [DATA_W-1:0] w_main_in_data;

  assign w_in_fire = bus.in_valid_i & bus.in_ready_o;
  assign w_cap_wen = bus.in_wen_i & ~((ZERO_REG_PROTECT != 0) && (bus.in_dst_i == '0));

  // Main refills whenever it is empty or being drained; the skid always goes first.
  assign w_main_take = ~w_main_vld | bus.out_ready_i;
  assign w_main_load = ~bus.flush_i & w_main_take & (w_skid_vld | w_in_fire);
  assign w_main_clr  = bus.flush_i | (w_main_take & ~w_skid_vld & ~w_in_fire);
  assign w_skid_load = ~bus.flush_i & w_in_fire & (w_skid_vld | ~w_main_take);
  assign w_skid_clr  = bus.flush_i | (w_main_take & w_skid_vld & ~w_in_fire);

  assign w_main_in_dst  = w_skid_vld ? w_skid_dst  : bus.in_dst_i;
  assign w_main_in_wen  = w_skid_vld ? w_skid_wen  : w_cap_wen;
  assign w_main_in_data = w_skid_vld ? w_skid_data : bus.in_data_i;

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_clr  (w_main_clr),
    .i_dst  (w_main_in_dst),
    .i_wen  (w_main_in_wen),
    .i_data (w_main_in_data),
    .o_vld  (w_main_vld),
    .o_dst  (w_main_dst),
    .o_wen  (w_main_wen),
    .o_data (w_main_data)
  );

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_clr  (w_skid_clr),
    .i_dst  (bus.in_dst_i),
    .i_wen  (w_cap_wen),
    .i_data (bus.in_data_i),
    .o_vld  (w_skid_vld),
    .o_dst  (w_skid_dst),
    .o_wen  (w_skid_wen),
    .o_data (w_skid_data)
  );

  assign bus.in_ready_o  = ~w_skid_vld;
  assign bus.out_valid_o = w_main_vld;
  assign bus.out_dst_o   = w_main_dst;
  assign bus.out_wen_o   = w_main_wen & w_main_vld;
  assign bus.out_data_o  = w_main_data;

`ifdef WB_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles the consumer held back a valid entry; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_vld & ~bus.out_ready_i & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
